axis_red_pitaya_adc_nch: RTL
============================

AXIS_RED_PITAYA_ADC_NCH -- requirements
Module: axis_red_pitaya_adc_nch

Interface
REQ-001 Parameter NCH, default 4: number of ADC channels, legal 1..8.
REQ-002 Parameter ADC_WIDTH, default 14: raw sample width per channel, legal 8..16.
REQ-003 Parameter OUT_WIDTH, default 16: output lane width per channel, legal ADC_WIDTH..32.
REQ-004 Parameter LOG2_DEC_MAX, default 8: maximum log2 decimation factor, legal 0..15.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 Port aclk, in, 1: sole clock, rising edge.
REQ-007 Port areset, in, 1: asynchronous active-high reset.
REQ-008 Port adc_dat_i, in, NCH*ADC_WIDTH: parallel raw samples, one per cycle; channel k is bits [k*ADC_WIDTH +: ADC_WIDTH].
REQ-009 Port cfg_invert, in, 1: 1 = Red Pitaya format (keep MSB, invert the remaining bits); 0 = raw two's complement.
REQ-010 Port cfg_log2_dec, in, 4: requested log2 decimation D.
REQ-011 Port ovf_clr_i, in, 1: clears the overflow flag.
REQ-012 Port m_axis_tdata, out, NCH*OUT_WIDTH: channel k result in lane [k*OUT_WIDTH +: OUT_WIDTH].
REQ-013 Port m_axis_tvalid, out, 1: output word valid.
REQ-014 Port m_axis_tready, in, 1: downstream accept.
REQ-015 Port ovf_o, out, 1: sticky flag indicating an unaccepted result was overwritten.

Function
REQ-016 Stage 1 SHALL register every channel on each aclk edge, converted per cfg_invert, and interpret the result as signed ADC_WIDTH.
REQ-017 Effective D SHALL be min(cfg_log2_dec, LOG2_DEC_MAX).
REQ-018 Effective D SHALL be latched only at a block start; changes mid-block SHALL take effect at the next block.
REQ-019 Each block SHALL span exactly 2^D consecutive stage-1 samples, counted by a block counter that wraps to 0 after 2^D-1.
REQ-020 The per-channel accumulator SHALL be signed ADC_WIDTH+LOG2_DEC_MAX bits and SHALL never saturate or wrap.
REQ-021 At block end, result = (sum of block samples) arithmetic-shifted right by D (floor toward minus infinity), then sign-extended to OUT_WIDTH.
REQ-022 At the edge after the block's last sample reaches stage 1, the result SHALL load into the output register and assert m_axis_tvalid.
REQ-023 The accumulator SHALL restart with the next sample on that same edge, so blocks are gapless.
REQ-024 Latency SHALL be: D=0 gives tvalid 2 edges after adc_dat_i is presented; D>0 gives tvalid 2 edges after the last sample of the block.
REQ-025 A transfer occurs when tvalid and tready are both 1; tvalid SHALL deassert after a transfer unless a new result loads on the same edge.
REQ-026 tdata SHALL be stable while tvalid=1 and tready=0, except on an overwrite (REQ-027).
REQ-027 A new result arriving while tvalid=1 and tready=0 SHALL overwrite tdata, keep tvalid=1, and set ovf_o.
REQ-028 A new result arriving on the same edge as a transfer SHALL NOT set ovf_o.
REQ-029 ovf_o SHALL clear on ovf_clr_i=1; if a set and a clear occur on the same edge, the set SHALL win.
REQ-030 The output rate with D=0 SHALL be one word per cycle when tready=1.

Reset
REQ-031 While areset=1, the following SHALL be 0 regardless of aclk: stage-1 registers, accumulators, block counter, m_axis_tdata, m_axis_tvalid, ovf_o.
REQ-032 Effective D SHALL load from cfg_log2_dec on the first edge after areset deasserts, which starts a new block.
REQ-033 Assertion of areset mid-block SHALL discard the partial block, with no result emitted.

Verification
REQ-034 Passthrough: NCH=4, ADC_WIDTH=14, OUT_WIDTH=16, D=0, cfg_invert=1, tready=1, ch0 raw 14'h1FFF, 14'h0000, 14'h2000 -> tdata[15:0] = 16'h0000, 16'h1FFF, 16'hFFFF on consecutive cycles, with first tvalid 2 edges after input.
REQ-035 Averaging: D=2, cfg_invert=0, ch1 = 10, 20, 30, 40 -> a single tvalid pulse with tdata[31:16] = 16'h0019; the next pulse arrives 4 cycles later.
REQ-036 Negative floor: D=1, ch2 = -3, -4 -> tdata[47:32] = 16'hFFFC (-4).
REQ-037 Backpressure: D=0, tready=0 for 3 cycles with inputs 1, 2, 3 -> tvalid stays 1, tdata = 3, ovf_o = 1; ovf_clr_i pulse -> ovf_o = 0; a simultaneous new overwrite and ovf_clr_i -> ovf_o = 1.
REQ-038 Mid-block config: D=2, cfg_log2_dec changed to 0 after the 2nd sample -> the current 4-sample block still completes, then one result per cycle follows.
REQ-039 Reset mid-block: D=3, areset pulsed after 5 samples -> tvalid = 0, tdata = 0; after release the first result covers exactly the next 8 samples.

Source files
------------

// File: rtl/axis_red_pitaya_adc_nch.sv
// ---------------------------------------------------------------------------
// axis_red_pitaya_adc_nch
//
// Multi-channel ADC front end with block-average decimation and an
// AXI-Stream style output register.
//
// Each cycle every channel is registered (optionally converted from the
// Red Pitaya offset format), accumulated over a block of 2^D samples, and at
// block end the floor-average (sum >>> D) is presented on m_axis_tdata.
//
// Handshake: a word moves when m_axis_tvalid && m_axis_tready on a rising
// aclk edge. tvalid stays high with stable tdata until accepted, except when
// a new result arrives first: it then overwrites tdata and sets the sticky
// ovf_o flag (cleared by ovf_clr_i, a simultaneous set wins).
//
// Ports
//   aclk, areset        : clock, asynchronous active-high reset
//   adc_dat_i           : NCH packed raw samples, channel k at [k*ADC_WIDTH +: ADC_WIDTH]
//   cfg_invert          : 1 = keep MSB / invert the rest, 0 = raw two's complement
//   cfg_log2_dec        : requested log2 decimation, clamped to LOG2_DEC_MAX
//   ovf_clr_i           : clears ovf_o
//   m_axis_tdata/tvalid/tready : output stream, lane k at [k*OUT_WIDTH +: OUT_WIDTH]
//   ovf_o               : sticky overwrite flag
// ---------------------------------------------------------------------------
module axis_red_pitaya_adc_nch #(
    parameter int NCH          = 4,
    parameter int ADC_WIDTH    = 14,
    parameter int OUT_WIDTH    = 16,
    parameter int LOG2_DEC_MAX = 8
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [NCH*ADC_WIDTH-1:0] adc_dat_i,
    input  logic                     cfg_invert,
    input  logic [3:0]               cfg_log2_dec,
    input  logic                     ovf_clr_i,
    output logic [NCH*OUT_WIDTH-1:0] m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     ovf_o
);

    // Accumulator holds 2^LOG2_DEC_MAX samples without wrapping.
    localparam int         AW   = ADC_WIDTH + LOG2_DEC_MAX;
    localparam int         CW   = 16;
    localparam logic [3:0] DMAX = 4'(LOG2_DEC_MAX);

    logic [NCH*ADC_WIDTH-1:0] s1_q, s1_d;
    logic                     s1_vld_q, s1_vld_d;
    logic [NCH*AW-1:0]        acc_q, acc_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [3:0]               dec_q, dec_d;
    logic [NCH*OUT_WIDTH-1:0] tdata_q, tdata_d;
    logic                     tvalid_q, tvalid_d;
    logic                     ovf_q, ovf_d;

    logic [3:0]               dec_eff;
    logic [CW-1:0]            cnt_last;
    logic                     blk_last;
    logic                     load;
    logic                     ovf_set;

    logic signed [AW-1:0]        sum [NCH];
    logic signed [AW-1:0]        shr [NCH];
    logic signed [OUT_WIDTH-1:0] res [NCH];

    // Per-channel sum including the sample currently in stage 1, and its
    // floor-average. The average always lies inside the ADC range, so
    // resizing the shifted value to OUT_WIDTH (truncate or sign-extend) is exact.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            sum[k] = signed'(acc_q[k*AW +: AW])
                   + AW'(signed'(s1_q[k*ADC_WIDTH +: ADC_WIDTH]));
            shr[k] = sum[k] >>> dec_q;
            res[k] = OUT_WIDTH'(shr[k]);
        end
    end

    always_comb begin
        dec_eff  = (cfg_log2_dec > DMAX) ? DMAX : cfg_log2_dec;
        cnt_last = CW'((32'd1 << dec_q) - 32'd1);
        blk_last = (cnt_q == cnt_last);
        // s1_vld_q is low only on the first edge after reset: stage 1 holds
        // no real sample yet, and that edge opens the first block.
        load     = s1_vld_q && blk_last;
        ovf_set  = load && tvalid_q && !m_axis_tready;

        s1_d     = '0;
        s1_vld_d = 1'b1;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        dec_d    = dec_q;
        tdata_d  = tdata_q;

        for (int k = 0; k < NCH; k++) begin
            if (cfg_invert) begin
                s1_d[k*ADC_WIDTH +: ADC_WIDTH] = {adc_dat_i[k*ADC_WIDTH + ADC_WIDTH - 1],
                                                  ~adc_dat_i[k*ADC_WIDTH +: ADC_WIDTH - 1]};
            end else begin
                s1_d[k*ADC_WIDTH +: ADC_WIDTH] = adc_dat_i[k*ADC_WIDTH +: ADC_WIDTH];
            end
        end

        if (!s1_vld_q) begin
            dec_d = dec_eff;
        end else if (blk_last) begin
            // Block closes; the next sample starts a fresh block with the
            // decimation sampled right now, so blocks are gapless.
            cnt_d = '0;
            dec_d = dec_eff;
            acc_d = '0;
            for (int k = 0; k < NCH; k++) begin
                tdata_d[k*OUT_WIDTH +: OUT_WIDTH] = res[k];
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
            for (int k = 0; k < NCH; k++) begin
                acc_d[k*AW +: AW] = sum[k];
            end
        end

        tvalid_d = load || (tvalid_q && !m_axis_tready);
        ovf_d    = ovf_set || (ovf_q && !ovf_clr_i);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            s1_q     <= '0;
            s1_vld_q <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            dec_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s1_vld_q <= s1_vld_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            dec_q    <= dec_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign ovf_o         = ovf_q;

endmodule
